// File: rtl/dmem_responder.sv
// Variable-latency data memory responder for the MEM stage.
// A load/store request is latched in IDLE, the pipeline is held for LATENCY
// wait states, and the response (ack/rdata/err) is presented for one cycle.
// Stores commit on the clock edge that enters DONE; loads are read at that
// same edge, so a later load always sees the effect of an earlier store.

module dmem_responder #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemR,
   input  logic        MemWr,
   input  logic [1:0]  MemWrBits,
   input  logic [2:0]  MemRBits,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        ack,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int         DEPTH = 1 << ADDR_W;
   localparam int         AW    = ADDR_W + 2;
   localparam logic [3:0] LAT_C = 4'(LATENCY);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              armed_q;
   logic              rd_q, wr_q;
   logic [1:0]        wbits_q;
   logic [2:0]        rbits_q;
   logic [AW-1:0]     addr_q;
   logic [31:0]       wdata_q;
   logic              ack_q, err_q;
   logic [31:0]       rdata_q;
   logic [31:0]       mem_q [DEPTH];

   logic              req_s, accept_s, enter_done_s, we_s;
   logic              sel_rd_s, sel_wr_s, sel_err_s;
   logic [1:0]        sel_wbits_s;
   logic [2:0]        sel_rbits_s;
   logic [AW-1:0]     sel_addr_s;
   logic [31:0]       sel_wdata_s;
   logic [ADDR_W-1:0] sel_idx_s;
   logic [31:0]       cur_word_s;
   logic              unused_addr_s;

   // Flags misaligned, reserved-code and conflicting (load+store) requests.
   function automatic logic req_err(input logic rd, input logic wr,
                                    input logic [1:0] wb, input logic [2:0] rb,
                                    input logic [1:0] a);
      logic e;
      e = 1'b0;
      if (rd && wr) begin
         e = 1'b1;
      end else if (wr) begin
         case (wb)
            2'b00:   e = (a != 2'b00);
            2'b01:   e = a[0];
            2'b10:   e = 1'b0;
            default: e = 1'b1;
         endcase
      end else if (rd) begin
         case (rb)
            3'b000:         e = (a != 2'b00);
            3'b001, 3'b010: e = a[0];
            3'b011, 3'b100: e = 1'b0;
            default:        e = 1'b1;
         endcase
      end else begin
         e = 1'b0;
      end
      return e;
   endfunction

   // Selects the addressed lane of a word and sign/zero extends it.
   function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                input logic [2:0] rb,
                                                input logic [1:0] a);
      logic [15:0] h;
      logic [7:0]  b;
      logic [31:0] r;
      h = a[1] ? w[31:16] : w[15:0];
      case (a)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      case (rb)
         3'b000:  r = w;
         3'b001:  r = {{16{h[15]}}, h};
         3'b010:  r = {16'h0000, h};
         3'b011:  r = {{24{b[7]}}, b};
         3'b100:  r = {24'h000000, b};
         default: r = 32'h0000_0000;
      endcase
      return r;
   endfunction

   // Merges store data into the old word on the lanes chosen by width/address.
   function automatic logic [31:0] store_merge(input logic [31:0] old,
                                               input logic [31:0] wd,
                                               input logic [1:0] wb,
                                               input logic [1:0] a);
      logic [31:0] r;
      r = old;
      case (wb)
         2'b00: r = wd;
         2'b01: begin
            if (a[1]) begin
               r = {wd[15:0], old[15:0]};
            end else begin
               r = {old[31:16], wd[15:0]};
            end
         end
         2'b10: begin
            case (a)
               2'd0:    r = {old[31:8], wd[7:0]};
               2'd1:    r = {old[31:16], wd[7:0], old[7:0]};
               2'd2:    r = {old[31:24], wd[7:0], old[15:0]};
               default: r = {wd[7:0], old[23:0]};
            endcase
         end
         default: r = old;
      endcase
      return r;
   endfunction

   // Address bits above the array index wrap and are deliberately ignored.
   assign unused_addr_s = ^addr[31:AW];

   // armed_q blocks request acceptance while reset is (or was just) asserted.
   assign req_s    = armed_q & (MemR | MemWr);
   assign accept_s = (state_q == S_IDLE) && req_s;

   // Chooses live inputs in IDLE (zero-latency path) or the latched request.
   always_comb begin
      sel_rd_s    = rd_q;
      sel_wr_s    = wr_q;
      sel_wbits_s = wbits_q;
      sel_rbits_s = rbits_q;
      sel_addr_s  = addr_q;
      sel_wdata_s = wdata_q;
      if (state_q == S_IDLE) begin
         sel_rd_s    = MemR;
         sel_wr_s    = MemWr;
         sel_wbits_s = MemWrBits;
         sel_rbits_s = MemRBits;
         sel_addr_s  = addr[AW-1:0];
         sel_wdata_s = wdata;
      end else begin
         sel_rd_s    = rd_q;
         sel_wr_s    = wr_q;
         sel_wbits_s = wbits_q;
         sel_rbits_s = rbits_q;
         sel_addr_s  = addr_q;
         sel_wdata_s = wdata_q;
      end
   end

   assign sel_idx_s  = sel_addr_s[AW-1:2];
   assign cur_word_s = mem_q[sel_idx_s];
   assign sel_err_s  = req_err(sel_rd_s, sel_wr_s, sel_wbits_s, sel_rbits_s, sel_addr_s[1:0]);

   // Next-state logic: IDLE accepts, WAIT counts down, DONE always returns.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req_s) begin
               cnt_d = LAT_C;
               if (LAT_C == 4'd0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_WAIT;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = S_DONE;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   assign enter_done_s = (state_q != S_DONE) && (state_d == S_DONE);
   assign we_s         = enter_done_s && sel_wr_s && !sel_err_s;

   // State, counter and reset-release arming register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         armed_q <= 1'b1;
      end
   end

   // Captures the request fields when it is accepted in IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         wbits_q <= 2'b00;
         rbits_q <= 3'b000;
         addr_q  <= '0;
         wdata_q <= 32'h0000_0000;
      end else if (accept_s) begin
         rd_q    <= MemR;
         wr_q    <= MemWr;
         wbits_q <= MemWrBits;
         rbits_q <= MemRBits;
         addr_q  <= addr[AW-1:0];
         wdata_q <= wdata;
      end
   end

   // Registered response, valid only in the DONE cycle and zero otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'h0000_0000;
      end else if (enter_done_s) begin
         ack_q   <= 1'b1;
         err_q   <= sel_err_s;
         rdata_q <= (sel_rd_s && !sel_err_s) ?
                    load_extract(cur_word_s, sel_rbits_s, sel_addr_s[1:0]) : 32'h0000_0000;
      end else begin
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'h0000_0000;
      end
   end

   // Storage array; not reset, written only on the edge entering DONE.
   always_ff @(posedge clk) begin
      if (we_s) begin
         mem_q[sel_idx_s] <= store_merge(cur_word_s, sel_wdata_s, sel_wbits_s, sel_addr_s[1:0]);
      end
   end

   assign stall = accept_s || (state_q == S_WAIT);
   assign ack   = ack_q;
   assign err   = err_q;
   assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// load/store traffic compared against a byte-addressed reference memory.

module tb_dmem_responder;

   localparam int LAT = 2;

   logic        clk;
   logic        rst;
   logic        MemR, MemWr;
   logic [1:0]  MemWrBits;
   logic [2:0]  MemRBits;
   logic [31:0] addr, wdata;
   logic        stall, ack, err;
   logic [31:0] rdata;

   logic        m0_rd, m0_wr;
   logic [1:0]  m0_wb;
   logic [2:0]  m0_rb;
   logic [31:0] m0_addr, m0_wdata;
   logic        m0_stall, m0_ack, m0_err;
   logic [31:0] m0_rdata;

   int n_chk;
   int n_fail;

   logic [7:0] mb [4096];

   dmem_responder #(.ADDR_W(10), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .MemR(MemR), .MemWr(MemWr), .MemWrBits(MemWrBits),
      .MemRBits(MemRBits), .addr(addr), .wdata(wdata), .stall(stall), .ack(ack),
      .rdata(rdata), .err(err)
   );

   dmem_responder #(.ADDR_W(10), .LATENCY(0)) dut0 (
      .clk(clk), .rst(rst), .MemR(m0_rd), .MemWr(m0_wr), .MemWrBits(m0_wb),
      .MemRBits(m0_rb), .addr(m0_addr), .wdata(m0_wdata), .stall(m0_stall), .ack(m0_ack),
      .rdata(m0_rdata), .err(m0_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One request on the LATENCY=2 instance, checked against the byte model.
   task automatic run_op(input string tag, input logic rd, input logic wr,
                         input logic [1:0] wb, input logic [2:0] rb,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] got, output logic got_err);
      bit          e;
      bit          sg;
      int unsigned n;
      int unsigned base;
      logic [31:0] ev;
      int          cyc;
      e = 1'b0; sg = 1'b0; n = 0;
      if (wr) begin
         case (wb)
            2'd0: n = 4;
            2'd1: n = 2;
            2'd2: n = 1;
            default: n = 0;
         endcase
      end else begin
         case (rb)
            3'd0: n = 4;
            3'd1: begin n = 2; sg = 1'b1; end
            3'd2: n = 2;
            3'd3: begin n = 1; sg = 1'b1; end
            3'd4: n = 1;
            default: n = 0;
         endcase
      end
      if (rd && wr) e = 1'b1;
      else if (n == 0) e = 1'b1;
      else if ((a % n) != 0) e = 1'b1;
      base = a & 32'h0000_0FFF;
      ev = 32'h0;
      if (!e && rd) begin
         for (int i = 0; i < int'(n); i++) ev = ev | (32'(mb[base + i]) << (8 * i));
         if (sg && ev[8*n-1]) ev = ev | (32'hFFFF_FFFF << (8 * n));
      end

      MemR = rd; MemWr = wr; MemWrBits = wb; MemRBits = rb; addr = a; wdata = wd;
      #1;
      check_eq({tag, "/stall_req"}, 32'(stall), 32'd1);
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
         if (!ack) check_eq({tag, "/stall_wait"}, 32'(stall), 32'd1);
      end while (!ack && cyc < 16);
      check_eq({tag, "/latency"}, 32'(cyc), 32'(LAT + 1));
      check_eq({tag, "/err"}, 32'(err), 32'(e));
      check_eq({tag, "/rdata"}, rdata, ev);
      check_eq({tag, "/stall_done"}, 32'(stall), 32'd0);
      got = rdata;
      got_err = err;
      MemR = 1'b0; MemWr = 1'b0;
      @(posedge clk); #1;
      check_eq({tag, "/ack_clr"}, 32'(ack), 32'd0);
      check_eq({tag, "/err_clr"}, 32'(err), 32'd0);
      check_eq({tag, "/rdata_clr"}, rdata, 32'd0);
      if (!e && wr) begin
         for (int i = 0; i < int'(n); i++) mb[base + i] = 8'(wd >> (8 * i));
      end
   endtask

   initial begin
      logic [31:0] g;
      logic        ge;
      logic [31:0] d0;
      int          kind;
      logic [1:0]  wb;
      logic [2:0]  rb;
      logic [31:0] a;
      n_chk = 0; n_fail = 0;
      m0_rd = 1'b0; m0_wr = 1'b0; m0_wb = 2'b00; m0_rb = 3'b000; m0_addr = 32'h0; m0_wdata = 32'h0;

      // Reset with a request held: outputs must stay quiet.
      rst = 1'b0; MemR = 1'b1; MemWr = 1'b0; MemWrBits = 2'b00; MemRBits = 3'b000;
      addr = 32'h10; wdata = 32'h0;
      #3;
      check_eq("rst/stall", 32'(stall), 32'd0);
      check_eq("rst/ack", 32'(ack), 32'd0);
      check_eq("rst/err", 32'(err), 32'd0);
      check_eq("rst/rdata", rdata, 32'd0);
      repeat (3) @(negedge clk);
      check_eq("rst/stall_clk", 32'(stall), 32'd0);
      MemR = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Basic store then load.
      run_op("sw10", 1'b0, 1'b1, 2'd0, 3'd0, 32'h10, 32'hDEAD_BEEF, g, ge);
      check_eq("sw10/ack_err", 32'(ge), 32'd0);
      run_op("lw10", 1'b1, 1'b0, 2'd0, 3'd0, 32'h10, 32'h0, g, ge);
      check_eq("lw10/val", g, 32'hDEAD_BEEF);

      // Byte store and sub-word loads with extension.
      run_op("sb11", 1'b0, 1'b1, 2'd2, 3'd0, 32'h11, 32'h0000_00AA, g, ge);
      run_op("lw10b", 1'b1, 1'b0, 2'd0, 3'd0, 32'h10, 32'h0, g, ge);
      check_eq("lw10b/val", g, 32'hDEAD_AAEF);
      run_op("lb11", 1'b1, 1'b0, 2'd0, 3'd3, 32'h11, 32'h0, g, ge);
      check_eq("lb11/val", g, 32'hFFFF_FFAA);
      run_op("lbu11", 1'b1, 1'b0, 2'd0, 3'd4, 32'h11, 32'h0, g, ge);
      check_eq("lbu11/val", g, 32'h0000_00AA);
      run_op("lh12", 1'b1, 1'b0, 2'd0, 3'd1, 32'h12, 32'h0, g, ge);
      check_eq("lh12/val", g, 32'hFFFF_DEAD);
      run_op("lhu10", 1'b1, 1'b0, 2'd0, 3'd2, 32'h10, 32'h0, g, ge);
      check_eq("lhu10/val", g, 32'h0000_AAEF);

      // Error cases: no write, rdata zero.
      run_op("sh13", 1'b0, 1'b1, 2'd1, 3'd0, 32'h13, 32'h0000_1234, g, ge);
      check_eq("sh13/err", 32'(ge), 32'd1);
      run_op("lw06", 1'b1, 1'b0, 2'd0, 3'd0, 32'h06, 32'h0, g, ge);
      check_eq("lw06/err", 32'(ge), 32'd1);
      check_eq("lw06/rdata", g, 32'd0);
      run_op("both", 1'b1, 1'b1, 2'd0, 3'd0, 32'h10, 32'h1111_1111, g, ge);
      check_eq("both/err", 32'(ge), 32'd1);
      run_op("lw10c", 1'b1, 1'b0, 2'd0, 3'd0, 32'h10, 32'h0, g, ge);
      check_eq("lw10c/val", g, 32'hDEAD_AAEF);

      // Reset during WAIT of a store abandons it.
      run_op("sw20z", 1'b0, 1'b1, 2'd0, 3'd0, 32'h20, 32'h0, g, ge);
      MemWr = 1'b1; MemR = 1'b0; MemWrBits = 2'd0; addr = 32'h20; wdata = 32'h1234_5678;
      @(posedge clk); #1;
      check_eq("mid/stall_wait", 32'(stall), 32'd1);
      #2 rst = 1'b0;
      #1;
      check_eq("mid/stall", 32'(stall), 32'd0);
      check_eq("mid/ack", 32'(ack), 32'd0);
      check_eq("mid/err", 32'(err), 32'd0);
      MemWr = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      run_op("lw20", 1'b1, 1'b0, 2'd0, 3'd0, 32'h20, 32'h0, g, ge);
      check_eq("lw20/val", g, 32'h0000_0000);

      // Address wrap.
      run_op("sw1004", 1'b0, 1'b1, 2'd0, 3'd0, 32'h1004, 32'h0000_0055, g, ge);
      run_op("lw0004", 1'b1, 1'b0, 2'd0, 3'd0, 32'h0004, 32'h0, g, ge);
      check_eq("lw0004/val", g, 32'h0000_0055);

      // Randomized traffic over 16 preloaded words with aliasing upper bits.
      for (int w = 0; w < 16; w++)
         run_op($sformatf("pre%0d", w), 1'b0, 1'b1, 2'd0, 3'd0, 32'(w * 4), $urandom, g, ge);
      for (int i = 0; i < 150; i++) begin
         kind = $urandom_range(0, 9);
         wb = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         rb = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
         if (kind < 4)
            run_op($sformatf("rnd%0d", i), 1'b0, 1'b1, wb, rb, a, $urandom, g, ge);
         else if (kind < 9)
            run_op($sformatf("rnd%0d", i), 1'b1, 1'b0, wb, rb, a, 32'h0, g, ge);
         else
            run_op($sformatf("rnd%0d", i), 1'b1, 1'b1, wb, rb, a, $urandom, g, ge);
      end

      // Zero-latency instance: alternating sw/lw held continuously.
      for (int j = 0; j < 8; j++) begin
         if ((j % 2) == 0) begin
            d0 = $urandom;
            m0_wr = 1'b1; m0_rd = 1'b0; m0_wb = 2'd0; m0_addr = 32'(32'h40 + 4 * (j / 2)); m0_wdata = d0;
         end else begin
            m0_wr = 1'b0; m0_rd = 1'b1; m0_rb = 3'd0;
         end
         if (j > 0) begin
            @(posedge clk); #1;
            check_eq($sformatf("l0_%0d/ack_idle", j), 32'(m0_ack), 32'd0);
            check_eq($sformatf("l0_%0d/stall_idle", j), 32'(m0_stall), 32'd1);
         end
         @(posedge clk); #1;
         check_eq($sformatf("l0_%0d/ack", j), 32'(m0_ack), 32'd1);
         check_eq($sformatf("l0_%0d/err", j), 32'(m0_err), 32'd0);
         check_eq($sformatf("l0_%0d/rdata", j), m0_rdata, ((j % 2) == 0) ? 32'd0 : d0);
      end
      m0_rd = 1'b0; m0_wr = 1'b0;
      @(posedge clk); #1;
      check_eq("l0/ack_clr", 32'(m0_ack), 32'd0);
      check_eq("l0/rdata_clr", m0_rdata, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
